// File: rtl/button_conditioner_if.sv
// Board-side bundle for the arrow-button front end: raw buttons and pause in,
// conditioned levels, press pulses and chord events out.
interface button_conditioner_if;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       pause;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] chord;
    logic       chord_valid;

    modport master (
        output btnU, btnD, btnL, btnR, pause,
        input  btn_level, press_pulse, chord, chord_valid
    );

    modport slave (
        input  btnU, btnD, btnL, btnR, pause,
        output btn_level, press_pulse, chord, chord_valid
    );
endinterface

// File: rtl/button_conditioner.sv
// Arrow-button conditioner: per-button synchroniser, debouncer and press-edge
// detector, followed by a chord collector merging presses inside a time window.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DB_BITS         = 20,
    parameter int unsigned CHORD_CYCLES    = 2000000,
    parameter int unsigned CH_BITS         = 21
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_conditioner_if.slave  bus
);

    localparam logic [DB_BITS-1:0] DB_MAX = DB_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CH_BITS-1:0] CH_MAX = CH_BITS'(CHORD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    logic [3:0]              raw_s;
    logic [3:0]              sync1_q, sync1_d;
    logic [3:0]              sync2_q, sync2_d;
    logic [3:0][DB_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]              level_q, level_d;
    logic [3:0]              pulse_q, pulse_d;
    state_t                  state_q, state_d;
    logic [3:0]              acc_q, acc_d;
    logic [CH_BITS-1:0]      timer_q, timer_d;
    logic [3:0]              chord_q, chord_d;
    logic                    chord_valid_q, chord_valid_d;

    assign raw_s = {bus.btnU, bus.btnD, bus.btnL, bus.btnR};

    // Synchronise, debounce and detect the rising edge of each button level.
    always_comb begin
        sync1_d = raw_s;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_BITS'(1);
            end
        end
        // The pulse is registered alongside the level so both appear in the same cycle.
        pulse_d = level_d & ~level_q;
    end

    // Chord collector: next state, accumulator, window timer and strobe.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        timer_d       = timer_q;
        chord_d       = chord_q;
        chord_valid_d = 1'b0;
        if (bus.pause) begin
            state_d = IDLE;
            acc_d   = 4'b0000;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (pulse_q != 4'b0000) begin
                        state_d = COLLECT;
                        acc_d   = pulse_q;
                    end else begin
                        acc_d = 4'b0000;
                    end
                end
                COLLECT: begin
                    acc_d = acc_q | pulse_q;
                    if (timer_q == CH_MAX) begin
                        // Strobe is registered on entry so it is visible during EMIT.
                        state_d       = EMIT;
                        chord_d       = acc_q | pulse_q;
                        chord_valid_d = 1'b1;
                        timer_d       = '0;
                    end else begin
                        timer_d = timer_q + CH_BITS'(1);
                    end
                end
                EMIT: begin
                    timer_d = '0;
                    if (pulse_q != 4'b0000) begin
                        state_d = COLLECT;
                        acc_d   = pulse_q;
                    end else begin
                        state_d = IDLE;
                        acc_d   = 4'b0000;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = 4'b0000;
                    timer_d = '0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= 4'b0000;
            sync2_q       <= 4'b0000;
            cnt_q         <= '0;
            level_q       <= 4'b0000;
            pulse_q       <= 4'b0000;
            state_q       <= IDLE;
            acc_q         <= 4'b0000;
            timer_q       <= '0;
            chord_q       <= 4'b0000;
            chord_valid_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            pulse_q       <= pulse_d;
            state_q       <= state_d;
            acc_q         <= acc_d;
            timer_q       <= timer_d;
            chord_q       <= chord_d;
            chord_valid_q <= chord_valid_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.press_pulse = pulse_q;
    assign bus.chord       = chord_q;
    assign bus.chord_valid = chord_valid_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomised checks of button_conditioner against a window-based
// behavioural model (debounce by sample history, chords by window start/deadline).
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int CH = 8;

    logic clk;
    logic reset_n;
    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .DB_BITS(20),
        .CHORD_CYCLES(CH),
        .CH_BITS(21)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000;
    logic [3:0] m_level = 4'b0000, m_pulse = 4'b0000, m_chord = 4'b0000;
    logic       m_valid = 1'b0;
    logic [3:0] m_hist [D];
    bit         win_open = 1'b0;
    int         win_start = 0;
    logic [3:0] win_acc = 4'b0000;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // Model of one clock edge given the inputs held during cycle cyc.
    task automatic model_edge(input logic [3:0] raw, input logic pz, input logic rn);
        logic [3:0] nl;
        bit all_diff;
        if (!rn) begin
            m_s1 = 4'b0000; m_s2 = 4'b0000; m_level = 4'b0000; m_pulse = 4'b0000;
            m_chord = 4'b0000; m_valid = 1'b0; win_open = 1'b0; win_acc = 4'b0000;
            for (int j = 0; j < D; j++) m_hist[j] = 4'b0000;
        end else begin
            for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s2;
            // A level flips once the last D synced samples all disagree with it.
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) if (m_hist[j][i] == m_level[i]) all_diff = 1'b0;
                nl[i] = all_diff ? ~m_level[i] : m_level[i];
            end
            m_valid = 1'b0;
            if (pz) begin
                win_open = 1'b0;
            end else if (win_open && cyc == win_start + CH) begin
                m_chord  = win_acc | m_pulse;
                m_valid  = 1'b1;
                win_open = 1'b0;
            end else if (win_open) begin
                win_acc = win_acc | m_pulse;
            end else if (m_pulse != 4'b0000) begin
                win_open  = 1'b1;
                win_start = cyc;
                win_acc   = m_pulse;
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_pulse = nl & ~m_level;
            m_level = nl;
        end
    endtask

    task automatic tick();
        model_edge({bus.btnU, bus.btnD, bus.btnL, bus.btnR}, bus.pause, reset_n);
        @(posedge clk);
        cyc++;
        #1;
        chk("btn_level", bus.btn_level, m_level);
        chk("press_pulse", bus.press_pulse, m_pulse);
        chk("chord", bus.chord, m_chord);
        chk("chord_valid", {3'b000, bus.chord_valid}, {3'b000, m_valid});
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int t0;
    int t1;
    int npulse;
    int nvalid;

    initial begin
        for (int j = 0; j < D; j++) m_hist[j] = 4'b0000;
        reset_n = 1'b0;
        bus.btnU = 1'b0; bus.btnD = 1'b0; bus.btnL = 1'b0; bus.btnR = 1'b0; bus.pause = 1'b0;
        tick(); tick();
        chk("reset_level", bus.btn_level, 4'b0000);
        chk("reset_valid", {3'b000, bus.chord_valid}, 4'b0000);
        reset_n = 1'b1;
        idle(3);

        // Single clean press on U.
        t0 = cyc; bus.btnU = 1'b1;
        run_to(t0 + 5);
        chk("u_level_early", bus.btn_level, 4'b0000);
        tick();
        chk("u_level", bus.btn_level, 4'b1000);
        chk("u_pulse", bus.press_pulse, 4'b1000);
        tick();
        chk("u_pulse_once", bus.press_pulse, 4'b0000);
        run_to(t0 + 14);
        chk("u_no_early_strobe", {3'b000, bus.chord_valid}, 4'b0000);
        tick();
        chk("u_strobe", {3'b000, bus.chord_valid}, 4'b0001);
        chk("u_chord", bus.chord, 4'b1000);
        tick();
        chk("u_strobe_once", {3'b000, bus.chord_valid}, 4'b0000);
        chk("u_chord_hold", bus.chord, 4'b1000);
        bus.btnU = 1'b0;
        idle(14);

        // Bouncing L: exactly one pulse once it settles high.
        t0 = cyc; npulse = 0;
        for (int k = 0; k < 30; k++) begin
            bus.btnL = (k >= 8) ? 1'b1 : (((k / 2) % 2) == 0);
            tick();
            if (bus.press_pulse[1]) npulse++;
        end
        chk("l_bounce_pulses", 4'(npulse), 4'd1);
        bus.btnL = 1'b0;
        idle(14);

        // U then R eight cycles later: merged into one chord.
        t0 = cyc; bus.btnU = 1'b1;
        run_to(t0 + 8); bus.btnR = 1'b1;
        run_to(t0 + 15);
        chord_chk: begin
            chk("ur_strobe", {3'b000, bus.chord_valid}, 4'b0001);
            chk("ur_chord", bus.chord, 4'b1001);
        end
        idle(12);
        bus.btnU = 1'b0; bus.btnR = 1'b0;
        idle(14);

        // R nine cycles after U: R starts the next chord.
        t0 = cyc; bus.btnU = 1'b1;
        run_to(t0 + 9); bus.btnR = 1'b1;
        run_to(t0 + 15);
        chk("split_strobe1", {3'b000, bus.chord_valid}, 4'b0001);
        chk("split_chord1", bus.chord, 4'b1000);
        run_to(t0 + 24);
        chk("split_strobe2", {3'b000, bus.chord_valid}, 4'b0001);
        chk("split_chord2", bus.chord, 4'b0001);
        bus.btnU = 1'b0; bus.btnR = 1'b0;
        idle(14);

        // Pause mid-window discards the chord.
        t0 = cyc; bus.btnD = 1'b1; nvalid = 0;
        run_to(t0 + 9); bus.pause = 1'b1;
        tick(); tick();
        bus.pause = 1'b0;
        while (cyc < t0 + 30) begin
            tick();
            if (bus.chord_valid) nvalid++;
        end
        chk("pause_no_strobe", 4'(nvalid), 4'd0);
        chk("pause_level_d", {3'b000, bus.btn_level[2]}, 4'b0001);
        bus.btnD = 1'b0;
        idle(12);
        t1 = cyc; bus.btnD = 1'b1;
        run_to(t1 + 15);
        chk("pause_fresh_strobe", {3'b000, bus.chord_valid}, 4'b0001);
        chk("pause_fresh_chord", bus.chord, 4'b0100);
        bus.btnD = 1'b0;
        idle(12);

        // Reset mid-window with L held.
        t0 = cyc; bus.btnL = 1'b1; nvalid = 0;
        run_to(t0 + 10); reset_n = 1'b0;
        tick();
        chk("rst_level", bus.btn_level, 4'b0000);
        chk("rst_pulse", bus.press_pulse, 4'b0000);
        chk("rst_chord", bus.chord, 4'b0000);
        chk("rst_valid", {3'b000, bus.chord_valid}, 4'b0000);
        reset_n = 1'b1;
        while (cyc < t0 + 16) begin
            tick();
            if (bus.chord_valid) nvalid++;
        end
        chk("rst_no_strobe", 4'(nvalid), 4'd0);
        chk("rst_level_early", bus.btn_level, 4'b0000);
        tick();
        chk("rst_repulse", bus.press_pulse, 4'b0010);
        bus.btnL = 1'b0;
        idle(14);

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) bus.btnU = ~bus.btnU;
            if ($urandom_range(0, 7) == 0) bus.btnD = ~bus.btnD;
            if ($urandom_range(0, 7) == 0) bus.btnL = ~bus.btnL;
            if ($urandom_range(0, 7) == 0) bus.btnR = ~bus.btnR;
            bus.pause = ($urandom_range(0, 24) == 0);
            reset_n   = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n = 1'b1; bus.pause = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
